uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, character width.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2^DEPTH_LOG2 entries.
REQ-003 SHALL have parameter IRQ_THRESH, default 2, low-water level for irq_o (used only with UART_TXFIFO_IRQ_EN).
REQ-004 SHALL have port clk_i, input, 1, single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n_i, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port rst_soft_i, input, 1, synchronous flush, active-high.
REQ-007 SHALL have port tx_en_i, input, 1, drain enable.
REQ-008 SHALL have port wr_en_i, input, 1, bus write strobe for one character.
REQ-009 SHALL have port wr_data_i, input, DATA_W, character to enqueue.
REQ-010 SHALL have port full_o, output, 1, FIFO full.
REQ-011 SHALL have port empty_o, output, 1, FIFO empty.
REQ-012 SHALL have port level_o, output, DEPTH_LOG2+1, occupied entries.
REQ-013 SHALL have port ovf_o, output, 1, sticky overflow flag.
REQ-014 SHALL have port core_tx_ready_i, input, 1, serializer idle (from uart_core tx_ready).
REQ-015 SHALL have port core_data_o, output, DATA_W, character to serializer.
REQ-016 SHALL have port core_write_en_o, output, 1, one-cycle load strobe to serializer.
REQ-017 SHALL have port irq_o, output, 1, low-water interrupt (present only with UART_TXFIFO_IRQ_EN).

Function
REQ-018 SHALL accept a write iff wr_en_i=1 and full_o=0 at that edge; write pointer increments mod 2^DEPTH_LOG2.
REQ-019 SHALL drop a write when full_o=1, even if a pop occurs the same cycle, and set ovf_o=1.
REQ-020 SHALL update level_o +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-021 SHALL derive full_o = (level_o == 2^DEPTH_LOG2) and empty_o = (level_o == 0), registered.
REQ-022 SHALL run drain FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_READY.
REQ-023 IDLE -> ISSUE when tx_en_i=1, empty_o=0, core_tx_ready_i=1; else stay.
REQ-024 ISSUE SHALL last exactly one cycle: core_write_en_o=1, core_data_o=head entry, read pointer advances (pop); then -> WAIT_BUSY.
REQ-025 WAIT_BUSY -> WAIT_READY when core_tx_ready_i=0; WAIT_READY -> IDLE when core_tx_ready_i=1.
REQ-026 core_data_o SHALL hold the last issued character until the next ISSUE.
REQ-027 First character written into an empty FIFO with core idle and tx_en_i=1 SHALL produce core_write_en_o=1 exactly two cycles after the write cycle.
REQ-028 tx_en_i falling mid-transfer SHALL NOT abort WAIT_BUSY/WAIT_READY; only new ISSUE is blocked.
REQ-029 core_write_en_o SHALL never be high on two consecutive cycles.

Reset
REQ-030 rst_n_i=0 at an edge SHALL set pointers=0, level_o=0, empty_o=1, full_o=0, ovf_o=0, core_write_en_o=0, core_data_o=0, FSM=IDLE, irq_o=0 when present.
REQ-031 rst_soft_i=1 SHALL have the same effect as rst_n_i=0 and take priority over a same-cycle write or issue.
REQ-032 Reset during WAIT_BUSY/WAIT_READY SHALL return FSM to IDLE; the in-flight character is not re-issued.
REQ-033 Stored data array SHALL NOT require reset.

Configuration
REQ-034 Macro UART_TXFIFO_IRQ_EN defined: irq_o present, registered, =1 when level_o <= IRQ_THRESH and tx_en_i=1, else 0.
REQ-035 Macro UART_TXFIFO_IRQ_EN undefined: irq_o port and its logic absent; all other behaviour identical.

Verification
REQ-036 Reset, write 0x41 with core_tx_ready_i=1, tx_en_i=1 -> core_write_en_o=1 two cycles later, core_data_o=0x41, level_o returns to 0.
REQ-037 tx_en_i=0, write 16 chars 0x00..0x0F -> full_o=1, level_o=16; 17th write 0xFF -> dropped, ovf_o=1, level_o=16.
REQ-038 Full FIFO, tx_en_i=1, core toggles ready low 3 cycles/high -> 16 strobes in order 0x00..0x0F, never back-to-back, empty_o=1 at end.
REQ-039 Simultaneous write and ISSUE at level_o=5 -> level_o stays 5; rst_soft_i pulse in WAIT_BUSY -> level_o=0, FSM IDLE, no further strobe.
REQ-040 With UART_TXFIFO_IRQ_EN, IRQ_THRESH=2, drain from 4 -> irq_o rises the cycle after level_o reaches 2; cleared by filling to 3.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Bus-side write port and serializer-side load port of the UART transmit FIFO.
// The slave modport is the FIFO; the master modport is the host/core environment.
interface uart_tx_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic                  wr_en_i;
  logic [DATA_W-1:0]     wr_data_i;
  logic                  full_o;
  logic                  empty_o;
  logic [DEPTH_LOG2:0]   level_o;
  logic                  ovf_o;
  logic                  core_tx_ready_i;
  logic [DATA_W-1:0]     core_data_o;
  logic                  core_write_en_o;

  modport master (
    output wr_en_i, wr_data_i, core_tx_ready_i,
    input  full_o, empty_o, level_o, ovf_o, core_data_o, core_write_en_o
  );

  modport slave (
    input  wr_en_i, wr_data_i, core_tx_ready_i,
    output full_o, empty_o, level_o, ovf_o, core_data_o, core_write_en_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a UART serializer one character per load strobe.
// Optional low-water interrupt irq_o is built when UART_TXFIFO_IRQ_EN is defined.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int IRQ_THRESH = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic rst_soft_i,
  input  logic tx_en_i,
  uart_tx_fifo_if.slave bus
`ifdef UART_TXFIFO_IRQ_EN
  ,
  output logic irq_o
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_READY
  } state_t;

  if (IRQ_THRESH < 0 || IRQ_THRESH > DEPTH) begin : g_thresh_check
    $error("uart_tx_fifo: IRQ_THRESH must lie in 0..2**DEPTH_LOG2");
  end

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [LW-1:0]         level_next;
  logic                  clear;
  logic                  push;
  logic                  pop;
  state_t                state;

  // Soft flush behaves exactly like the hard reset and wins over any same-cycle activity.
  assign clear = !rst_n_i || rst_soft_i;
  // full_o is the registered flag, so a write at full is dropped even if a pop lands this cycle.
  assign push  = bus.wr_en_i && !bus.full_o;
  assign pop   = (state == ISSUE);

  // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred.
  always_comb begin
    level_next = bus.level_o;
    case ({push, pop})
      2'b10:   level_next = bus.level_o + LW'(1);
      2'b01:   level_next = bus.level_o - LW'(1);
      default: level_next = bus.level_o;
    endcase
  end

  // NOTE: the storage array carries no reset; pointers and level alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= bus.wr_data_i;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      bus.level_o <= '0;
      bus.full_o  <= 1'b0;
      bus.empty_o <= 1'b1;
      bus.ovf_o   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      bus.level_o <= level_next;
      bus.full_o  <= (level_next == LW'(DEPTH));
      bus.empty_o <= (level_next == '0);
      if (bus.wr_en_i && bus.full_o) bus.ovf_o <= 1'b1;
    end
  end

  // Drain FSM: a character is loaded only when the serializer is idle, then the
  // FSM waits for the busy/idle handshake before it may issue the next one.
  always_ff @(posedge clk_i) begin
    if (clear) begin
      state               <= IDLE;
      bus.core_write_en_o <= 1'b0;
      bus.core_data_o     <= '0;
    end else begin
      bus.core_write_en_o <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_en_i && !bus.empty_o && bus.core_tx_ready_i) begin
            state               <= ISSUE;
            bus.core_write_en_o <= 1'b1;
            bus.core_data_o     <= mem[rd_ptr];
          end
        end
        ISSUE:      state <= WAIT_BUSY;
        // Transfers already handed to the core finish even if tx_en_i drops.
        WAIT_BUSY:  if (!bus.core_tx_ready_i) state <= WAIT_READY;
        WAIT_READY: if (bus.core_tx_ready_i)  state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

`ifdef UART_TXFIFO_IRQ_EN
  always_ff @(posedge clk_i) begin
    if (clear) irq_o <= 1'b0;
    else       irq_o <= tx_en_i && (bus.level_o <= LW'(IRQ_THRESH));
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted writes queue their expected character,
// a monitor pops and compares on every serializer load strobe.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_soft = 1'b0;
  logic tx_en = 1'b0;
`ifdef UART_TXFIFO_IRQ_EN
  logic irq;
`endif

  uart_tx_fifo_if #(.DATA_W(8), .DEPTH_LOG2(4)) bus ();

  uart_tx_fifo #(.DATA_W(8), .DEPTH_LOG2(4), .IRQ_THRESH(2)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .rst_soft_i (rst_soft),
    .tx_en_i    (tx_en),
    .bus        (bus)
`ifdef UART_TXFIFO_IRQ_EN
    ,
    .irq_o      (irq)
`endif
  );

  always #5 clk = ~clk;

  int       n_checks  = 0;
  int       n_err     = 0;
  int       n_strobes = 0;
  int       busy_cycles = 3;
  bit       core_auto = 1'b1;
  bit       prev_we   = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_char(input logic [7:0] d, input bit accepted);
    bus.wr_en_i   = 1'b1;
    bus.wr_data_i = d;
    if (accepted) exp_q.push_back(d);
    tick();
    bus.wr_en_i = 1'b0;
  endtask

  task automatic wait_drained(input int max_cycles, input string name);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (bus.empty_o && exp_q.size() == 0 && bus.core_tx_ready_i) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check(done, name, 32'(exp_q.size()), 32'd0);
  endtask

  // Serializer model: after each load strobe, ready drops for busy_cycles cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (core_auto && bus.core_write_en_o) begin
        @(posedge clk);
        #1 bus.core_tx_ready_i = 1'b0;
        repeat (busy_cycles) @(posedge clk);
        #1 bus.core_tx_ready_i = 1'b1;
      end
    end
  end

  // Monitor: compare every strobe against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.core_write_en_o) begin
        n_strobes++;
        check(!prev_we, "no_back_to_back", 32'(prev_we), 32'd0);
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_strobe", 32'(bus.core_data_o), 32'd0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check(bus.core_data_o == e, "core_data", 32'(bus.core_data_o), 32'(e));
        end
      end
      prev_we = bus.core_write_en_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;
    bit hit;
    bus.wr_en_i         = 1'b0;
    bus.wr_data_i       = '0;
    bus.core_tx_ready_i = 1'b1;

    // Reset state
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check(bus.level_o == 0, "rst_level", 32'(bus.level_o), 32'd0);
    check(bus.empty_o == 1, "rst_empty", 32'(bus.empty_o), 32'd1);
    check(bus.full_o == 0, "rst_full", 32'(bus.full_o), 32'd0);
    check(bus.ovf_o == 0, "rst_ovf", 32'(bus.ovf_o), 32'd0);
    check(bus.core_write_en_o == 0, "rst_we", 32'(bus.core_write_en_o), 32'd0);
    check(bus.core_data_o == 0, "rst_data", 32'(bus.core_data_o), 32'd0);

    // Single character: strobe exactly two cycles after the write cycle
    tx_en = 1'b1;
    write_char(8'h41, 1'b1);
    check(bus.core_write_en_o == 0, "lat_plus1", 32'(bus.core_write_en_o), 32'd0);
    tick();
    check(bus.core_write_en_o == 1, "lat_plus2", 32'(bus.core_write_en_o), 32'd1);
    check(bus.core_data_o == 8'h41, "lat_data", 32'(bus.core_data_o), 32'h41);
    repeat (8) tick();
    check(bus.level_o == 0, "single_level", 32'(bus.level_o), 32'd0);
    check(bus.empty_o == 1, "single_empty", 32'(bus.empty_o), 32'd1);

    // Fill to full with drain disabled, then overflow
    tx_en = 1'b0;
    for (int i = 0; i < 16; i++) write_char(8'(i), 1'b1);
    check(bus.full_o == 1, "fill_full", 32'(bus.full_o), 32'd1);
    check(bus.level_o == 16, "fill_level", 32'(bus.level_o), 32'd16);
    check(bus.ovf_o == 0, "fill_no_ovf", 32'(bus.ovf_o), 32'd0);
    write_char(8'hFF, 1'b0);
    check(bus.ovf_o == 1, "ovf_set", 32'(bus.ovf_o), 32'd1);
    check(bus.level_o == 16, "ovf_level", 32'(bus.level_o), 32'd16);
    check(bus.full_o == 1, "ovf_full", 32'(bus.full_o), 32'd1);

    // Drain all 16 in order through the handshake
    tx_en = 1'b1;
    wait_drained(400, "drain16_timeout");
    check(bus.empty_o == 1, "drain16_empty", 32'(bus.empty_o), 32'd1);
    check(bus.level_o == 0, "drain16_level", 32'(bus.level_o), 32'd0);
    check(n_strobes == 17, "drain16_strobes", 32'(n_strobes), 32'd17);
    check(bus.ovf_o == 1, "ovf_sticky", 32'(bus.ovf_o), 32'd1);

    // Simultaneous push and pop at level 5, then soft flush in WAIT_BUSY
    tx_en = 1'b0;
    for (int i = 0; i < 5; i++) write_char(8'h50 + 8'(i), 1'b1);
    check(bus.level_o == 5, "lvl5", 32'(bus.level_o), 32'd5);
    tx_en = 1'b1;
    tick();
    check(bus.core_write_en_o == 1, "issue_at5", 32'(bus.core_write_en_o), 32'd1);
    write_char(8'h55, 1'b1);
    check(bus.level_o == 5, "push_pop_level", 32'(bus.level_o), 32'd5);
    rst_soft = 1'b1;
    tx_en    = 1'b0;
    tick();
    rst_soft = 1'b0;
    exp_q.delete();
    check(bus.level_o == 0, "soft_level", 32'(bus.level_o), 32'd0);
    check(bus.empty_o == 1, "soft_empty", 32'(bus.empty_o), 32'd1);
    check(bus.ovf_o == 0, "soft_ovf", 32'(bus.ovf_o), 32'd0);
    check(bus.core_data_o == 0, "soft_data", 32'(bus.core_data_o), 32'd0);
    snap = n_strobes;
    tx_en = 1'b1;
    repeat (20) tick();
    check(n_strobes == snap, "soft_no_strobe", 32'(n_strobes), 32'(snap));

    // FSM back in IDLE: a fresh character issues with the two-cycle latency
    write_char(8'h66, 1'b1);
    check(bus.core_write_en_o == 0, "post_soft_plus1", 32'(bus.core_write_en_o), 32'd0);
    tick();
    check(bus.core_write_en_o == 1, "post_soft_plus2", 32'(bus.core_write_en_o), 32'd1);
    wait_drained(50, "post_soft_timeout");

`ifdef UART_TXFIFO_IRQ_EN
    // Low-water interrupt: rises the cycle after level reaches 2, clears on refill to 3
    tx_en = 1'b0;
    busy_cycles = 8;
    for (int i = 0; i < 4; i++) write_char(8'h70 + 8'(i), 1'b1);
    tx_en = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.level_o == 2) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    check(hit, "irq_reach2", 32'(bus.level_o), 32'd2);
    check(irq == 0, "irq_before", 32'(irq), 32'd0);
    tick();
    check(irq == 1, "irq_rise", 32'(irq), 32'd1);
    wait_drained(200, "irq_drain_timeout");
    core_auto = 1'b0;
    bus.core_tx_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) write_char(8'h80 + 8'(i), 1'b1);
    check(bus.level_o == 3, "irq_fill3", 32'(bus.level_o), 32'd3);
    tick();
    check(irq == 0, "irq_clear", 32'(irq), 32'd0);
    busy_cycles = 3;
    core_auto = 1'b1;
    bus.core_tx_ready_i = 1'b1;
    wait_drained(100, "irq_final_timeout");
`endif

    repeat (5) tick();
    check(exp_q.size() == 0, "scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
